// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates an active-low column drive, synchronizes the rows,
// debounces press and release, and emits one valid strobe with the key code per press.
module keypad_scanner #(
    parameter int SCAN_DIV = 16,
    parameter int DEBOUNCE = 64
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic       v,
    output logic [3:0] code,
    output logic       key_down
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(DEBOUNCE);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] DEB_LAST   = BW'(DEBOUNCE - 1);

    typedef enum logic [1:0] {
        ST_SCAN = 2'd0,
        ST_DEB  = 2'd1,
        ST_EMIT = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    state_t        state_r;
    logic [3:0]    sync1_r;
    logic [3:0]    rs_r;
    logic [1:0]    col_idx_r;
    logic [1:0]    row_idx_r;
    logic [DW-1:0] dwell_r;
    logic [BW-1:0] deb_r;
    logic [3:0]    col_r;
    logic          v_r;
    logic [3:0]    code_r;
    logic          key_down_r;
    logic [1:0]    col_next_s;

    // Lowest-index low row wins when several keys in one column are pressed.
    function automatic logic [1:0] lowest_low(input logic [3:0] r);
        logic [1:0] idx;
        idx = 2'd0;
        if (r[0] == 1'b0) begin
            idx = 2'd0;
        end else if (r[1] == 1'b0) begin
            idx = 2'd1;
        end else if (r[2] == 1'b0) begin
            idx = 2'd2;
        end else begin
            idx = 2'd3;
        end
        return idx;
    endfunction

    function automatic logic [3:0] col_drive(input logic [1:0] idx);
        logic [3:0] d;
        case (idx)
            2'd0:    d = 4'b1110;
            2'd1:    d = 4'b1101;
            2'd2:    d = 4'b1011;
            2'd3:    d = 4'b0111;
            default: d = 4'b1110;
        endcase
        return d;
    endfunction

    assign col_next_s = col_idx_r + 2'd1;

    // Two-flop synchronizer for the asynchronous row inputs; idle level is all-high.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_r <= 4'hF;
            rs_r    <= 4'hF;
        end else begin
            sync1_r <= row;
            rs_r    <= sync1_r;
        end
    end

    // Scan / debounce / emit / hold state machine with registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_SCAN;
            col_idx_r  <= 2'd0;
            row_idx_r  <= 2'd0;
            dwell_r    <= '0;
            deb_r      <= '0;
            col_r      <= 4'b1110;
            v_r        <= 1'b0;
            code_r     <= 4'h0;
            key_down_r <= 1'b0;
        end else begin
            v_r <= 1'b0;
            case (state_r)
                ST_SCAN: begin
                    if (dwell_r == DWELL_LAST) begin
                        if (rs_r != 4'hF) begin
                            row_idx_r <= lowest_low(rs_r);
                            deb_r     <= '0;
                            state_r   <= ST_DEB;
                        end else begin
                            col_idx_r <= col_next_s;
                            col_r     <= col_drive(col_next_s);
                            dwell_r   <= '0;
                        end
                    end else begin
                        dwell_r <= dwell_r + DW'(1);
                    end
                end
                ST_DEB: begin
                    // Only the latched row decides; a single high sample aborts the press.
                    if (rs_r[row_idx_r] == 1'b0) begin
                        if (deb_r == DEB_LAST) begin
                            state_r <= ST_EMIT;
                        end else begin
                            deb_r <= deb_r + BW'(1);
                        end
                    end else begin
                        col_idx_r <= col_next_s;
                        col_r     <= col_drive(col_next_s);
                        dwell_r   <= '0;
                        state_r   <= ST_SCAN;
                    end
                end
                ST_EMIT: begin
                    v_r        <= 1'b1;
                    code_r     <= {row_idx_r, col_idx_r};
                    key_down_r <= 1'b1;
                    deb_r      <= '0;
                    state_r    <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (rs_r == 4'hF) begin
                        if (deb_r == DEB_LAST) begin
                            key_down_r <= 1'b0;
                            col_idx_r  <= col_next_s;
                            col_r      <= col_drive(col_next_s);
                            dwell_r    <= '0;
                            state_r    <= ST_SCAN;
                        end else begin
                            deb_r <= deb_r + BW'(1);
                        end
                    end else begin
                        deb_r <= '0;
                    end
                end
                default: begin
                    state_r <= ST_SCAN;
                end
            endcase
        end
    end

    assign col      = col_r;
    assign v        = v_r;
    assign code     = code_r;
    assign key_down = key_down_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a behavioural keypad drives the rows and a code
// scoreboard is filled on each intended press and drained on each v strobe.
module tb_keypad_scanner;

    localparam int SD = 4;
    localparam int DB = 8;

    logic       clock;
    logic       reset;
    logic [3:0] row;
    logic [3:0] col;
    logic       v;
    logic [3:0] code;
    logic       key_down;

    logic [15:0] keys;
    logic [3:0]  glitch;
    logic [3:0]  exp_q[$];
    logic        prev_v;
    int          checks;
    int          failures;

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
        .clock    (clock),
        .reset    (reset),
        .row      (row),
        .col      (col),
        .v        (v),
        .code     (code),
        .key_down (key_down)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Keypad: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && (col[c] == 1'b0)) begin
                    row[r] = 1'b0;
                end
            end
        end
        row = row & ~glitch;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
        if (v === 1'b1) begin
            chk("v_back_to_back", {31'd0, prev_v}, 32'd0);
            checks++;
            assert (exp_q.size() > 0) else begin
                failures++;
                $error("FAIL unexpected_v observed code=0x%0h expected no strobe", code);
            end
            if (exp_q.size() > 0) begin
                chk("code", {28'd0, code}, {28'd0, exp_q.pop_front()});
                chk("key_down_at_v", {31'd0, key_down}, 32'd1);
            end
        end
        prev_v = v;
    endtask

    task automatic wait_col(input logic [3:0] target, input int budget);
        int n;
        n = 0;
        while (col !== target && n < budget) begin
            step();
            n++;
        end
        chk("wait_col", {28'd0, col}, {28'd0, target});
    endtask

    task automatic wait_v(input int budget, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (v !== 1'b1 && n < budget);
        chk("v_seen", {31'd0, v}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n;
        int         idx;
        logic [3:0] one_hot;
        logic [3:0] exp_col;

        checks   = 0;
        failures = 0;
        prev_v   = 1'b0;
        keys     = 16'h0;
        glitch   = 4'h0;
        reset    = 1'b0;
        one_hot  = 4'b0001;

        repeat (3) step();
        chk("reset_col", {28'd0, col}, 32'hE);
        chk("reset_v", {31'd0, v}, 32'd0);
        chk("reset_code", {28'd0, code}, 32'h0);
        chk("reset_key_down", {31'd0, key_down}, 32'd0);

        // Idle scan: each column held SD cycles, wrapping back to column 0.
        reset = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            idx     = (k / SD) % 4;
            exp_col = ~(one_hot << idx);
            chk("idle_col", {28'd0, col}, {28'd0, exp_col});
        end
        chk("idle_v", {31'd0, v}, 32'd0);
        chk("idle_code", {28'd0, code}, 32'h0);

        // Single press row 2 / column 2.
        wait_col(4'b1011, 40);
        keys[10] = 1'b1;
        exp_q.push_back(4'hA);
        wait_v(40, n);
        chk("press_latency", n, SD + DB + 1);
        chk("press_key_down", {31'd0, key_down}, 32'd1);
        repeat (27) step();
        chk("hold_key_down", {31'd0, key_down}, 32'd1);
        chk("hold_col_frozen", {28'd0, col}, 32'hB);
        keys = 16'h0;
        repeat (9) step();
        chk("release_early", {31'd0, key_down}, 32'd1);
        step();
        chk("release_key_down", {31'd0, key_down}, 32'd0);
        chk("release_next_col", {28'd0, col}, 32'h7);

        // Bounce: row 1 / column 1 low for only 5 debounce cycles.
        wait_col(4'b1101, 40);
        keys[5] = 1'b1;
        repeat (7) step();
        keys = 16'h0;
        repeat (3) step();
        chk("bounce_next_col", {28'd0, col}, 32'hB);
        chk("bounce_key_down", {31'd0, key_down}, 32'd0);
        repeat (20) step();
        chk("bounce_code_kept", {28'd0, code}, 32'hA);

        // Two keys in column 0: lowest row wins, remaining key only keeps HOLD.
        wait_col(4'b1110, 40);
        keys[12] = 1'b1;
        keys[0]  = 1'b1;
        exp_q.push_back(4'h0);
        wait_v(40, n);
        keys[0] = 1'b0;
        repeat (20) step();
        chk("two_key_hold", {31'd0, key_down}, 32'd1);
        keys = 16'h0;
        repeat (10) step();
        chk("two_key_release", {31'd0, key_down}, 32'd0);
        chk("two_key_next_col", {28'd0, col}, 32'hD);

        // Release bounce: row glitches every 5 cycles keep HOLD alive.
        wait_col(4'b0111, 40);
        keys[7] = 1'b1;
        exp_q.push_back(4'h7);
        wait_v(40, n);
        keys = 16'h0;
        for (int g = 0; g < 6; g++) begin
            repeat (4) step();
            glitch = 4'b0001;
            step();
            glitch = 4'h0;
            chk("glitch_hold", {31'd0, key_down}, 32'd1);
        end
        repeat (9) step();
        chk("glitch_release_early", {31'd0, key_down}, 32'd1);
        step();
        chk("glitch_release", {31'd0, key_down}, 32'd0);

        // Asynchronous reset in HOLD with the key still held.
        wait_col(4'b1101, 40);
        keys[9] = 1'b1;
        exp_q.push_back(4'h9);
        wait_v(40, n);
        repeat (3) step();
        #2 reset = 1'b0;
        #1;
        chk("async_col", {28'd0, col}, 32'hE);
        chk("async_v", {31'd0, v}, 32'd0);
        chk("async_key_down", {31'd0, key_down}, 32'd0);
        chk("async_code", {28'd0, code}, 32'h0);
        step();
        reset = 1'b1;
        exp_q.push_back(4'h9);
        wait_v(40, n);
        chk("post_reset_latency", n, 4 + SD + DB + 1);
        keys = 16'h0;
        repeat (10) step();
        chk("final_key_down", {31'd0, key_down}, 32'd0);
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
